asid_tlb: RTL and testbench
===========================

// Module: asid_tlb
// PURPOSE
// - Fully-associative Sv32 TLB with ASID tags, 4 KiB and 4 MiB megapage entries, and selective SFENCE.VMA.
// - Sits between the fetch/LSU address stage and the page-table walker; one lookup per cycle.
// - Has a registered response and fill-slot replacement (first invalid entry, else round-robin).
// - A store to a clean page invalidates the entry, so the walker refetches it and sets D.
// PARAMETERS
// - ENTRY_COUNT  16  number of entries; power of two, >=2
// - VPN_WIDTH    20  virtual page number width (Sv32)
// - PPN_WIDTH    22  physical page number width (Sv32)
// - ASID_WIDTH   9   address-space id width (satp.ASID)
// PORTS
// - clk            in   1           clock
// - rst            in   1           reset; synchronous, active-high
// - req_valid      in   1           lookup request
// - req_vpn        in   VPN_WIDTH   lookup VPN
// - req_access     in   MemoryAccessType  Instruction/Load/Store
// - resp_valid     out  1           response for request of previous cycle
// - resp_hit       out  1           translation usable
// - resp_fault     out  1           page fault (hit on entry, permission denied)
// - resp_miss      out  1           walker must refill
// - resp_ppn       out  PPN_WIDTH   translated PPN (megapage: {ppn1, req_vpn[9:0]})
// - fill_valid     in   1           walker writes an entry
// - fill_vpn       in   VPN_WIDTH   VPN of the fill
// - fill_entry     in   AsidTlbEntry  ppn, flags{R,W,X,U,G,A,D}, megapage, fault
// - sfence_valid   in   1           SFENCE.VMA issue (single-cycle pulse)
// - sfence_use_vpn in   1           rs1!=x0: match sfence_vpn
// - sfence_use_asid in  1           rs2!=x0: match sfence_asid
// - sfence_vpn     in   VPN_WIDTH   SFENCE virtual page
// - sfence_asid    in   ASID_WIDTH  SFENCE ASID
// - csr_satp       in   csr_satp_t  mode, asid
// - csr_priv       in   Privilege   effective privilege
// - csr_sum        in   1           mstatus.SUM
// - csr_mxr        in   1           mstatus.MXR
// BEHAVIOUR
// - Reset: all valid bits 0, rr pointer 0, resp_* all 0.
// - Latency is 1 cycle: req in cycle N gives resp_* in N+1; resp_valid=req_valid delayed.
//   - When resp_valid=0, hit/fault/miss are 0.
// - Exactly one of hit/fault/miss is set when resp_valid=1.
// - Bare mode or Machine privilege: hit=1, ppn={'0,req_vpn}, no CAM access.
// - Match condition for entry e:
//   - valid && (e.G || e.asid==satp.asid);
//   - megapage: e.vpn[19:10]==req_vpn[19:10]; else full VPN equal.
// - Fault (checked in the same order as the current TLB):
//   - e.fault;
//   - S-mode && !SUM && U;
//   - U-mode && !U;
//   - Instr && !X;
//   - Load && !R && !(MXR && X);
//   - Store && !W.
//   - Also fault: megapage with ppn[9:0]!=0 (misaligned superpage).
// - Store hit, no fault, D=0: report miss and clear that entry's valid at the clock edge.
// - Fill slot selection:
//   - existing match of (fill_vpn, satp.asid, megapage) takes the slot;
//   - else the lowest-index invalid entry;
//   - else entry rr_ptr, and rr_ptr increments (wrapping at ENTRY_COUNT-1 -> 0).
//   - rr_ptr changes only on a round-robin fill.
//   - The fill stores asid=satp.asid; its G bit is taken from fill_entry.
// - SFENCE clears valid at the next edge for matching entries:
//   - !use_vpn && !use_asid: all entries;
//   - use_vpn only: VPN match, any ASID;
//   - use_asid only: asid match && !G;
//   - both: VPN match && asid match && !G.
// - Priority in one cycle: sfence > fill > dirty-invalidate.
//   - A fill in the same cycle as an sfence is dropped.
//   - A lookup in the same cycle sees the pre-edge state.
// - A satp.asid change needs no flush; a satp.mode change takes effect on the next request.
// - rst mid-operation: the in-flight response is dropped (resp_valid=0 the next cycle).
// STRUCTURE
// - In CacheTypes: AsidTlbEntry (ppn, flags, megapage, fault); AsidTlbFlags typedef.
// - Optional sub-module asid_tlb_match: one entry's tag compare.
//   - Inputs: entry, asid, vpn. Outputs: hit, sfence_hit.
//   - Instantiated ENTRY_COUNT times via generate.
// - Lowest-invalid encoder and PPN mux live in the top module.
// TESTING
// - Bare: satp.mode=Bare, req_vpn=0x12345 -> next cycle hit=1, ppn=0x012345.
// - 4K hit: fill vpn=0x00010 ppn=0x3ABCD RWXAD, asid 5; Load 0x00010 -> hit, ppn=0x3ABCD.
//   - Switch satp.asid to 6 -> miss.
// - Megapage: fill vpn=0x00400 ppn=0x00800 megapage G=1; Load 0x007FF -> ppn=0x00BFF, any ASID.
//   - Megapage ppn=0x00801 -> fault.
// - Dirty: W=1 D=0 entry; Store -> miss, and the next Load to it -> miss.
//   - Refill with D=1, then Store -> hit.
// - Replacement: 17 fills into 16 entries -> the 17th goes to entry 0 and rr_ptr=1.
//   - Refill of an existing VPN goes to the same slot and rr_ptr stays unchanged.
// - SFENCE: asid-only 5 keeps G entries and removes ASID 5 non-G entries.
//   - Same-cycle fill+sfence -> the fill is lost.
//   - rst=1 -> every lookup misses.

Source files
------------

// File: rtl/asid_tlb_pkg.sv
// Shared types for the ASID-tagged Sv32 TLB: CSR views, access kinds and entry layout.
package asid_tlb_pkg;

    localparam int unsigned VpnWidth  = 20;
    localparam int unsigned PpnWidth  = 22;
    localparam int unsigned AsidWidth = 9;
    localparam int unsigned MegaBits  = 10;

    typedef enum logic [1:0] {
        AccessInstruction = 2'd0,
        AccessLoad        = 2'd1,
        AccessStore       = 2'd2
    } MemoryAccessType;

    typedef enum logic [1:0] {
        PrivUser       = 2'd0,
        PrivSupervisor = 2'd1,
        PrivMachine    = 2'd3
    } Privilege;

    typedef enum logic {
        SatpBare = 1'b0,
        SatpSv32 = 1'b1
    } SatpMode;

    typedef struct packed {
        SatpMode                mode;
        logic [AsidWidth-1:0]   asid;
    } csr_satp_t;

    typedef struct packed {
        logic r;
        logic w;
        logic x;
        logic u;
        logic g;
        logic a;
        logic d;
    } AsidTlbFlags;

    typedef struct packed {
        logic [PpnWidth-1:0] ppn;
        AsidTlbFlags         flags;
        logic                megapage;
        logic                fault;
    } AsidTlbEntry;

    typedef struct packed {
        logic                 valid;
        logic [VpnWidth-1:0]  vpn;
        logic [AsidWidth-1:0] asid;
        AsidTlbEntry          entry;
    } AsidTlbSlot;

    // Megapages only tag on VPN[1]; 4 KiB pages tag on the whole VPN.
    function automatic logic vpn_match(input logic [VpnWidth-1:0] a,
                                       input logic [VpnWidth-1:0] b,
                                       input logic                mega);
        if (mega) return a[VpnWidth-1:MegaBits] == b[VpnWidth-1:MegaBits];
        return a == b;
    endfunction

endpackage

// File: rtl/asid_tlb_match.sv
// Tag compare for one TLB slot: lookup hit and SFENCE.VMA selection.
module asid_tlb_match
    import asid_tlb_pkg::*;
(
    input  AsidTlbSlot             entry,
    input  logic [AsidWidth-1:0]   asid,
    input  logic [VpnWidth-1:0]    vpn,
    input  logic                   sfence_use_vpn,
    input  logic                   sfence_use_asid,
    input  logic [VpnWidth-1:0]    sfence_vpn,
    input  logic [AsidWidth-1:0]   sfence_asid,
    output logic                   hit,
    output logic                   sfence_hit
);

    logic vpn_ok;
    logic sf_vpn_ok;
    logic sf_asid_ok;
    logic unused_fields;

    assign vpn_ok = vpn_match(entry.vpn, vpn, entry.entry.megapage);
    assign hit    = entry.valid && (entry.entry.flags.g || entry.asid == asid) && vpn_ok;

    // Global entries survive any ASID-qualified fence.
    assign sf_vpn_ok  = !sfence_use_vpn || vpn_match(entry.vpn, sfence_vpn, entry.entry.megapage);
    assign sf_asid_ok = !sfence_use_asid || (entry.asid == sfence_asid && !entry.entry.flags.g);
    assign sfence_hit = entry.valid && sf_vpn_ok && sf_asid_ok;

    assign unused_fields = ^{entry.entry.ppn, entry.entry.flags.r, entry.entry.flags.w,
                             entry.entry.flags.x, entry.entry.flags.u, entry.entry.flags.a,
                             entry.entry.flags.d, entry.entry.fault};

endmodule

// File: rtl/asid_tlb.sv
// Fully-associative Sv32 TLB with ASID tags, megapages, selective SFENCE.VMA and
// a registered one-cycle lookup response.
module asid_tlb
    import asid_tlb_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = 16,
    parameter int unsigned VPN_WIDTH   = VpnWidth,
    parameter int unsigned PPN_WIDTH   = PpnWidth,
    parameter int unsigned ASID_WIDTH  = AsidWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [VPN_WIDTH-1:0]  req_vpn,
    input  MemoryAccessType       req_access,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic                  resp_fault,
    output logic                  resp_miss,
    output logic [PPN_WIDTH-1:0]  resp_ppn,
    input  logic                  fill_valid,
    input  logic [VPN_WIDTH-1:0]  fill_vpn,
    input  AsidTlbEntry           fill_entry,
    input  logic                  sfence_valid,
    input  logic                  sfence_use_vpn,
    input  logic                  sfence_use_asid,
    input  logic [VPN_WIDTH-1:0]  sfence_vpn,
    input  logic [ASID_WIDTH-1:0] sfence_asid,
    input  csr_satp_t             csr_satp,
    input  Privilege              csr_priv,
    input  logic                  csr_sum,
    input  logic                  csr_mxr
);

    localparam int unsigned IdxWidth = $clog2(ENTRY_COUNT);

    AsidTlbSlot             slots_q [ENTRY_COUNT];
    AsidTlbSlot             slots_d [ENTRY_COUNT];
    logic [IdxWidth-1:0]    rr_q, rr_d;
    logic [ENTRY_COUNT-1:0] lookup_hit, sfence_hit, fill_match;

    generate
        for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_entry
            asid_tlb_match u_match (
                .entry           (slots_q[i]),
                .asid            (csr_satp.asid),
                .vpn             (req_vpn),
                .sfence_use_vpn  (sfence_use_vpn),
                .sfence_use_asid (sfence_use_asid),
                .sfence_vpn      (sfence_vpn),
                .sfence_asid     (sfence_asid),
                .hit             (lookup_hit[i]),
                .sfence_hit      (sfence_hit[i])
            );
            assign fill_match[i] = slots_q[i].valid && slots_q[i].asid == csr_satp.asid
                && slots_q[i].entry.megapage == fill_entry.megapage
                && vpn_match(slots_q[i].vpn, fill_vpn, fill_entry.megapage);
        end
    endgenerate

    logic                 hit_any;
    logic [IdxWidth-1:0]  hit_idx;
    AsidTlbEntry          hit_entry;
    logic                 bypass, perm_fault, dirty_inval;
    logic                 hit_d, fault_d, miss_d;
    logic [PPN_WIDTH-1:0] ppn_d;
    logic                 unused_flags;

    assign unused_flags = ^{hit_entry.flags.a, hit_entry.flags.g};

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
            if (lookup_hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IdxWidth'(i);
            end
        end
        hit_entry  = slots_q[hit_idx].entry;
        bypass     = csr_satp.mode == SatpBare || csr_priv == PrivMachine;
        perm_fault = hit_entry.fault
            || (csr_priv == PrivSupervisor && !csr_sum && hit_entry.flags.u)
            || (csr_priv == PrivUser && !hit_entry.flags.u)
            || (req_access == AccessInstruction && !hit_entry.flags.x)
            || (req_access == AccessLoad && !hit_entry.flags.r
                && !(csr_mxr && hit_entry.flags.x))
            || (req_access == AccessStore && !hit_entry.flags.w)
            || (hit_entry.megapage && hit_entry.ppn[MegaBits-1:0] != '0);
        // A clean page must be refetched so the walker can set D.
        dirty_inval = req_valid && !bypass && hit_any && !perm_fault
            && req_access == AccessStore && !hit_entry.flags.d;

        hit_d   = 1'b0;
        fault_d = 1'b0;
        miss_d  = 1'b0;
        ppn_d   = '0;
        if (req_valid) begin
            if (bypass) begin
                hit_d = 1'b1;
                ppn_d = PPN_WIDTH'(req_vpn);
            end else if (!hit_any || dirty_inval) begin
                miss_d = 1'b1;
            end else if (perm_fault) begin
                fault_d = 1'b1;
            end else begin
                hit_d = 1'b1;
                ppn_d = hit_entry.megapage
                    ? {hit_entry.ppn[PpnWidth-1:MegaBits], req_vpn[MegaBits-1:0]}
                    : hit_entry.ppn;
            end
        end
    end

    logic                fill_hit_any, inv_any;
    logic [IdxWidth-1:0] fill_hit_idx, inv_idx, fill_idx;
    logic                fill_use_rr;

    always_comb begin
        fill_hit_any = 1'b0;
        fill_hit_idx = '0;
        inv_any      = 1'b0;
        inv_idx      = '0;
        for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
            if (fill_match[i]) begin
                fill_hit_any = 1'b1;
                fill_hit_idx = IdxWidth'(i);
            end
            if (!slots_q[i].valid) begin
                inv_any = 1'b1;
                inv_idx = IdxWidth'(i);
            end
        end
        fill_use_rr = !fill_hit_any && !inv_any;
        fill_idx    = fill_hit_any ? fill_hit_idx : (inv_any ? inv_idx : rr_q);
    end

    always_comb begin
        slots_d = slots_q;
        rr_d    = rr_q;
        if (dirty_inval) slots_d[hit_idx].valid = 1'b0;
        if (fill_valid && !sfence_valid) begin
            slots_d[fill_idx] = '{valid: 1'b1, vpn: fill_vpn, asid: csr_satp.asid,
                                  entry: fill_entry};
            if (fill_use_rr) rr_d = rr_q + 1'b1;
        end
        if (sfence_valid) begin
            for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
                if (sfence_hit[i]) slots_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRY_COUNT); i++) slots_q[i] <= '0;
            rr_q       <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
            resp_miss  <= 1'b0;
            resp_ppn   <= '0;
        end else begin
            slots_q    <= slots_d;
            rr_q       <= rr_d;
            resp_valid <= req_valid;
            resp_hit   <= hit_d;
            resp_fault <= fault_d;
            resp_miss  <= miss_d;
            resp_ppn   <= ppn_d;
        end
    end

endmodule

// File: tb/tb_asid_tlb.sv
// Self-checking bench for asid_tlb: lookup vector table plus fill/fence/replacement sequences.
module tb_asid_tlb;
    import asid_tlb_pkg::*;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic [19:0]     req_vpn;
    MemoryAccessType req_access;
    logic            resp_valid, resp_hit, resp_fault, resp_miss;
    logic [21:0]     resp_ppn;
    logic            fill_valid;
    logic [19:0]     fill_vpn;
    AsidTlbEntry     fill_entry;
    logic            sfence_valid, sfence_use_vpn, sfence_use_asid;
    logic [19:0]     sfence_vpn;
    logic [8:0]      sfence_asid;
    csr_satp_t       csr_satp;
    Privilege        csr_priv;
    logic            csr_sum, csr_mxr;

    asid_tlb dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_vpn         (req_vpn),
        .req_access      (req_access),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_fault      (resp_fault),
        .resp_miss       (resp_miss),
        .resp_ppn        (resp_ppn),
        .fill_valid      (fill_valid),
        .fill_vpn        (fill_vpn),
        .fill_entry      (fill_entry),
        .sfence_valid    (sfence_valid),
        .sfence_use_vpn  (sfence_use_vpn),
        .sfence_use_asid (sfence_use_asid),
        .sfence_vpn      (sfence_vpn),
        .sfence_asid     (sfence_asid),
        .csr_satp        (csr_satp),
        .csr_priv        (csr_priv),
        .csr_sum         (csr_sum),
        .csr_mxr         (csr_mxr)
    );

    localparam logic [2:0] ResHit   = 3'b100;
    localparam logic [2:0] ResFault = 3'b010;
    localparam logic [2:0] ResMiss  = 3'b001;

    // Flag vectors ordered {r, w, x, u, g, a, d}.
    localparam logic [6:0] FlagsRwxad  = 7'b1110011;
    localparam logic [6:0] FlagsGRwxad = 7'b1110111;
    localparam logic [6:0] FlagsRuad   = 7'b1001011;
    localparam logic [6:0] FlagsXad    = 7'b0010011;
    localparam logic [6:0] FlagsRwa    = 7'b1100010;
    localparam logic [6:0] FlagsRwad   = 7'b1100011;

    typedef struct packed {
        logic [31:0] due;
        logic [2:0]  res;
        logic [21:0] ppn;
    } exp_t;

    typedef struct {
        logic [8:0]      asid;
        Privilege        priv;
        logic            sum;
        logic            mxr;
        logic [19:0]     vpn;
        MemoryAccessType acc;
        logic [2:0]      res;
        logic [21:0]     ppn;
    } vec_t;

    exp_t   exp_q[$];
    string  name_q[$];
    exp_t   mon_e;
    string  mon_n;
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    vec_t   vecs[18];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            check({mon_n, " valid"}, 32'(resp_valid), 32'd1);
            check({mon_n, " kind"}, 32'({resp_hit, resp_fault, resp_miss}), 32'(mon_e.res));
            if (mon_e.res == ResHit) check({mon_n, " ppn"}, 32'(resp_ppn), 32'(mon_e.ppn));
        end else if (resp_valid) begin
            check("unexpected response", 32'(resp_valid), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [2:0] res, input logic [21:0] ppn, input string name);
        exp_q.push_back('{due: 32'(cyc + 1), res: res, ppn: ppn});
        name_q.push_back(name);
    endtask

    task automatic lookup(input logic [19:0] vpn, input MemoryAccessType acc,
                          input logic [2:0] res, input logic [21:0] ppn, input string name);
        req_valid  = 1'b1;
        req_vpn    = vpn;
        req_access = acc;
        expect_resp(res, ppn, name);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic set_fill(input logic [19:0] vpn, input logic [21:0] ppn,
                            input logic [6:0] flags, input logic mega, input logic flt);
        fill_valid = 1'b1;
        fill_vpn   = vpn;
        fill_entry = '{ppn: ppn, flags: AsidTlbFlags'(flags), megapage: mega, fault: flt};
    endtask

    task automatic fill(input logic [19:0] vpn, input logic [21:0] ppn,
                        input logic [6:0] flags, input logic mega, input logic flt);
        set_fill(vpn, ppn, flags, mega, flt);
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic set_sfence(input logic uv, input logic ua, input logic [19:0] vpn,
                              input logic [8:0] asid);
        sfence_valid    = 1'b1;
        sfence_use_vpn  = uv;
        sfence_use_asid = ua;
        sfence_vpn      = vpn;
        sfence_asid     = asid;
    endtask

    task automatic sfence(input logic uv, input logic ua, input logic [19:0] vpn,
                          input logic [8:0] asid);
        set_sfence(uv, ua, vpn, asid);
        tick();
        sfence_valid = 1'b0;
    endtask

    task automatic set_csr(input logic [8:0] asid, input Privilege priv, input logic sum,
                           input logic mxr);
        csr_satp = '{mode: SatpSv32, asid: asid};
        csr_priv = priv;
        csr_sum  = sum;
        csr_mxr  = mxr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mkvec(input logic [8:0] asid, input Privilege priv, input logic sum,
                                   input logic mxr, input logic [19:0] vpn,
                                   input MemoryAccessType acc, input logic [2:0] res,
                                   input logic [21:0] ppn);
        vec_t v;
        v.asid = asid; v.priv = priv; v.sum = sum; v.mxr = mxr;
        v.vpn = vpn; v.acc = acc; v.res = res; v.ppn = ppn;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00010, AccessLoad,  ResHit,   22'h3ABCD);
        vecs[1]  = mkvec(9'd6, PrivSupervisor, 0, 0, 20'h00010, AccessLoad,  ResMiss,  22'h0);
        vecs[2]  = mkvec(9'd6, PrivSupervisor, 0, 0, 20'h007FF, AccessLoad,  ResHit,   22'h00BFF);
        vecs[3]  = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h007FF, AccessLoad,  ResHit,   22'h00BFF);
        vecs[4]  = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00C05, AccessLoad,  ResFault, 22'h0);
        vecs[5]  = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00030, AccessLoad,  ResFault, 22'h0);
        vecs[6]  = mkvec(9'd5, PrivSupervisor, 1, 0, 20'h00030, AccessLoad,  ResHit,   22'h11111);
        vecs[7]  = mkvec(9'd5, PrivUser,       0, 0, 20'h00030, AccessLoad,  ResHit,   22'h11111);
        vecs[8]  = mkvec(9'd5, PrivUser,       0, 0, 20'h00010, AccessLoad,  ResFault, 22'h0);
        vecs[9]  = mkvec(9'd5, PrivUser,       0, 0, 20'h00030, AccessStore, ResFault, 22'h0);
        vecs[10] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00010, AccessInstruction, ResHit,
                         22'h3ABCD);
        vecs[11] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00040, AccessLoad,  ResFault, 22'h0);
        vecs[12] = mkvec(9'd5, PrivSupervisor, 0, 1, 20'h00040, AccessLoad,  ResHit,   22'h22222);
        vecs[13] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00040, AccessInstruction, ResHit,
                         22'h22222);
        vecs[14] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00050, AccessLoad,  ResFault, 22'h0);
        vecs[15] = mkvec(9'd5, PrivMachine,    0, 0, 20'h00050, AccessLoad,  ResHit,   22'h00050);
        vecs[16] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00010, AccessStore, ResHit,   22'h3ABCD);
        vecs[17] = mkvec(9'd5, PrivSupervisor, 0, 0, 20'h00099, AccessLoad,  ResMiss,  22'h0);

        // A request during reset must not produce a response.
        rst = 1'b1;
        req_valid = 1'b1; req_vpn = 20'h12345; req_access = AccessLoad;
        fill_valid = 1'b0; fill_vpn = '0; fill_entry = '0;
        sfence_valid = 1'b0; sfence_use_vpn = 1'b0; sfence_use_asid = 1'b0;
        sfence_vpn = '0; sfence_asid = '0;
        csr_satp = '{mode: SatpBare, asid: 9'd0};
        csr_priv = PrivSupervisor; csr_sum = 1'b0; csr_mxr = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset kind", 32'({resp_hit, resp_fault, resp_miss}), 32'd0);
        check("reset ppn", 32'(resp_ppn), 32'd0);
        req_valid = 1'b0;
        tick();
        rst = 1'b0;

        lookup(20'h12345, AccessLoad, ResHit, 22'h012345, "bare");

        set_csr(9'd5, PrivSupervisor, 1'b0, 1'b0);
        fill(20'h00010, 22'h3ABCD, FlagsRwxad, 1'b0, 1'b0);
        fill(20'h00400, 22'h00800, FlagsGRwxad, 1'b1, 1'b0);
        fill(20'h00C00, 22'h00801, FlagsRwxad, 1'b1, 1'b0);
        fill(20'h00030, 22'h11111, FlagsRuad, 1'b0, 1'b0);
        fill(20'h00040, 22'h22222, FlagsXad, 1'b0, 1'b0);
        fill(20'h00050, 22'h33333, FlagsRwxad, 1'b0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            set_csr(vecs[i].asid, vecs[i].priv, vecs[i].sum, vecs[i].mxr);
            lookup(vecs[i].vpn, vecs[i].acc, vecs[i].res, vecs[i].ppn, $sformatf("vec%0d", i));
        end

        // Store to a clean page: miss, entry dropped, refill with D then hit.
        set_csr(9'd5, PrivSupervisor, 1'b0, 1'b0);
        fill(20'h00060, 22'h44444, FlagsRwa, 1'b0, 1'b0);
        lookup(20'h00060, AccessLoad,  ResHit,  22'h44444, "clean load");
        lookup(20'h00060, AccessStore, ResMiss, 22'h0,     "clean store");
        lookup(20'h00060, AccessLoad,  ResMiss, 22'h0,     "after dirty inval");
        fill(20'h00060, 22'h44444, FlagsRwad, 1'b0, 1'b0);
        lookup(20'h00060, AccessStore, ResHit,  22'h44444, "dirty store");

        // Round-robin replacement once all 16 slots are valid.
        do_reset();
        set_csr(9'd5, PrivSupervisor, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) fill(20'h00100 + 20'(i), 22'h01000 + 22'(i), FlagsRwxad, 0, 0);
        fill(20'h00200, 22'h02000, FlagsRwxad, 1'b0, 1'b0);
        lookup(20'h00100, AccessLoad, ResMiss, 22'h0,     "rr evict slot0");
        lookup(20'h00200, AccessLoad, ResHit,  22'h02000, "rr 17th fill");
        lookup(20'h00101, AccessLoad, ResHit,  22'h01001, "rr slot1 kept");
        fill(20'h00200, 22'h02222, FlagsRwxad, 1'b0, 1'b0);
        fill(20'h00201, 22'h02001, FlagsRwxad, 1'b0, 1'b0);
        lookup(20'h00200, AccessLoad, ResHit,  22'h02222, "refill same slot");
        lookup(20'h00201, AccessLoad, ResHit,  22'h02001, "rr next fill");
        lookup(20'h00101, AccessLoad, ResMiss, 22'h0,     "rr evict slot1");
        lookup(20'h00102, AccessLoad, ResHit,  22'h01002, "rr slot2 kept");

        // Selective SFENCE.VMA.
        do_reset();
        set_csr(9'd5, PrivSupervisor, 1'b0, 1'b0);
        fill(20'h00300, 22'h00300, FlagsGRwxad, 1'b0, 1'b0);
        fill(20'h00301, 22'h00301, FlagsRwxad, 1'b0, 1'b0);
        set_csr(9'd7, PrivSupervisor, 1'b0, 1'b0);
        fill(20'h00302, 22'h00302, FlagsRwxad, 1'b0, 1'b0);
        sfence(1'b0, 1'b1, 20'h0, 9'd5);
        set_csr(9'd5, PrivSupervisor, 1'b0, 1'b0);
        lookup(20'h00300, AccessLoad, ResHit,  22'h00300, "sfence asid keeps G");
        lookup(20'h00301, AccessLoad, ResMiss, 22'h0,     "sfence asid drops");
        set_csr(9'd7, PrivSupervisor, 1'b0, 1'b0);
        lookup(20'h00302, AccessLoad, ResHit,  22'h00302, "sfence other asid");
        sfence(1'b1, 1'b0, 20'h00302, 9'd0);
        lookup(20'h00302, AccessLoad, ResMiss, 22'h0,     "sfence vpn drops");
        lookup(20'h00300, AccessLoad, ResHit,  22'h00300, "sfence vpn keeps");

        set_fill(20'h00303, 22'h00303, FlagsRwxad, 1'b0, 1'b0);
        set_sfence(1'b1, 1'b0, 20'h003FF, 9'd0);
        tick();
        fill_valid = 1'b0;
        sfence_valid = 1'b0;
        lookup(20'h00303, AccessLoad, ResMiss, 22'h0, "fill lost to sfence");

        req_valid = 1'b1; req_vpn = 20'h00300; req_access = AccessLoad;
        set_sfence(1'b0, 1'b0, 20'h0, 9'd0);
        expect_resp(ResHit, 22'h00300, "lookup sees pre-fence");
        tick();
        req_valid = 1'b0;
        sfence_valid = 1'b0;
        lookup(20'h00300, AccessLoad, ResMiss, 22'h0, "sfence all");

        // Reset while a request is in flight.
        fill(20'h00305, 22'h00305, FlagsRwxad, 1'b0, 1'b0);
        req_valid = 1'b1; req_vpn = 20'h00305; req_access = AccessLoad;
        rst = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("reset drops response", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        lookup(20'h00305, AccessLoad, ResMiss, 22'h0, "post-reset miss");

        tick();
        tick();
        check("response drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
